// File: rtl/stack_pkg.sv
// Shared types and defaults for the operand stack controller and its register file.
package stack_pkg;

  localparam int STACK_WIDTH = 8;
  localparam int STACK_DEPTH = 16;

  // Winner of the push > pop > tos priority encoder.
  typedef enum logic [1:0] {
    CMD_NONE = 2'd0,
    CMD_PUSH = 2'd1,
    CMD_POP  = 2'd2,
    CMD_TOS  = 2'd3
  } stack_cmd_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_OUT  = 1'b1
  } stack_state_e;

  // Occupancy counter width: must hold 0..depth inclusive.
  function automatic int occ_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/stack_ctrl_if.sv
// Command/result bundle between the main FSM (master) and the stack controller (slave).
interface stack_ctrl_if
  import stack_pkg::*;
#(
  parameter int WIDTH = STACK_WIDTH,
  parameter int DEPTH = STACK_DEPTH
);
  localparam int CW = occ_width(DEPTH);

  logic             push;
  logic             pop;
  logic             tos;
  logic [WIDTH-1:0] din;
  logic             clr_err;
  logic [WIDTH-1:0] dout;
  logic             dvalid;
  logic [CW-1:0]    count;
  logic             empty;
  logic             full;
  logic             overflow;
  logic             underflow;

  modport master (
    output push, pop, tos, din, clr_err,
    input  dout, dvalid, count, empty, full, overflow, underflow
  );

  modport slave (
    input  push, pop, tos, din, clr_err,
    output dout, dvalid, count, empty, full, overflow, underflow
  );

endinterface

// File: rtl/stack_regfile.sv
// DEPTH x WIDTH stack storage: one synchronous write port, one combinational read port, no reset.
module stack_regfile #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_r [DEPTH];

  // Storage write; popped entries stay until overwritten.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/stack_ctrl.sv
// Operand stack controller: pointer, status flags and output FSM around stack_regfile.
module stack_ctrl
  import stack_pkg::*;
#(
  parameter int WIDTH = STACK_WIDTH,
  parameter int DEPTH = STACK_DEPTH
) (
  input  logic         clk,
  input  logic         rst,
  stack_ctrl_if.slave  bus
);

  localparam int CW = occ_width(DEPTH);
  localparam int AW = CW - 1;

  stack_cmd_e       cmd_s;
  stack_state_e     state_r;
  logic [CW-1:0]    count_r;
  logic [WIDTH-1:0] dout_r;
  logic             ovf_r;
  logic             unf_r;
  logic             empty_s;
  logic             full_s;
  logic             wr_ok_s;
  logic             rd_ok_s;
  logic             ovf_ev_s;
  logic             unf_ev_s;
  logic [AW-1:0]    rd_idx_s;
  logic [WIDTH-1:0] rdata_s;

  assign empty_s  = (count_r == CW'(0));
  assign full_s   = (count_r == CW'(DEPTH));
  // Low bits wrap naturally, so count==DEPTH reads entry DEPTH-1.
  assign rd_idx_s = count_r[AW-1:0] - AW'(1);

  // Priority encoder: push > pop > tos.
  always_comb begin
    cmd_s = CMD_NONE;
    if (bus.push) begin
      cmd_s = CMD_PUSH;
    end else if (bus.pop) begin
      cmd_s = CMD_POP;
    end else if (bus.tos) begin
      cmd_s = CMD_TOS;
    end else begin
      cmd_s = CMD_NONE;
    end
  end

  // Split the winning command into success and error events.
  always_comb begin
    wr_ok_s  = 1'b0;
    rd_ok_s  = 1'b0;
    ovf_ev_s = 1'b0;
    unf_ev_s = 1'b0;
    case (cmd_s)
      CMD_PUSH: begin
        wr_ok_s  = !full_s;
        ovf_ev_s = full_s;
      end
      CMD_POP, CMD_TOS: begin
        rd_ok_s  = !empty_s;
        unf_ev_s = empty_s;
      end
      default: begin
        wr_ok_s = 1'b0;
      end
    endcase
  end

  stack_regfile #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_regfile (
    .clk   (clk),
    .we    (wr_ok_s),
    .waddr (count_r[AW-1:0]),
    .wdata (bus.din),
    .raddr (rd_idx_s),
    .rdata (rdata_s)
  );

  // Output FSM, stack pointer, result register and sticky error flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= S_IDLE;
      count_r <= CW'(0);
      dout_r  <= WIDTH'(0);
      ovf_r   <= 1'b0;
      unf_r   <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE:  state_r <= rd_ok_s ? S_OUT : S_IDLE;
        S_OUT:   state_r <= rd_ok_s ? S_OUT : S_IDLE;
        default: state_r <= S_IDLE;
      endcase
      if (wr_ok_s) begin
        count_r <= count_r + CW'(1);
        dout_r  <= bus.din;
      end else if (rd_ok_s) begin
        dout_r <= rdata_s;
        if (cmd_s == CMD_POP) begin
          count_r <= count_r - CW'(1);
        end
      end
      // A fresh error outranks a coincident clear.
      ovf_r <= (ovf_r & !bus.clr_err) | ovf_ev_s;
      unf_r <= (unf_r & !bus.clr_err) | unf_ev_s;
    end
  end

  assign bus.dout      = dout_r;
  assign bus.dvalid    = (state_r == S_OUT);
  assign bus.count     = count_r;
  assign bus.empty     = empty_s;
  assign bus.full      = full_s;
  assign bus.overflow  = ovf_r;
  assign bus.underflow = unf_r;

endmodule

// File: doc/stack_ctrl.md
# stack_ctrl

Stack controller for the multicycle stack-machine datapath: owns the operand stack storage and stack pointer, and executes the push / pop / top-of-stack commands the main FSM issues one per state. It provides a registered top-of-stack value that loads into the A/B operand registers one cycle later, plus full/empty status and sticky overflow/underflow flags for debug and trap logic.

## Interface
- `WIDTH`, 8, data word width (matches memory/ALU word)
- `DEPTH`, 16, stack entries; power of two, ≥ 2
- `CW`, $clog2(DEPTH)+1, occupancy counter width (derived, not overridden)

- `clk`  in  1  system clock, rising edge
- `rst`  in  1  reset, asynchronous, active-low
- `push`  in  1  push `din` (single-cycle command strobe)
- `pop`  in  1  pop and present popped word
- `tos`  in  1  present current top without removing it
- `din`  in  WIDTH  data to push (ALU result or memory data, muxed upstream)
- `clr_err`  in  1  clear sticky error flags
- `dout`  out  WIDTH  registered result of last successful pop/tos/push
- `dvalid`  out  1  one-cycle pulse: `dout` updated by pop or tos
- `count`  out  CW  current occupancy, 0..DEPTH
- `empty`  out  1  `count == 0`
- `full`  out  1  `count == DEPTH`
- `overflow`  out  1  sticky: push attempted while full
- `underflow`  out  1  sticky: pop/tos attempted while empty

## Operation
- Command priority when multiple strobes are high in one cycle: push > pop > tos; lower-priority strobes are ignored with no side effects.
- Push, not full: `mem[count] <= din`, `count <= count+1`, `dout <= din`; `dvalid` stays 0.
- Push, full: no write, `count` and `dout` unchanged, `overflow <= 1`.
- Pop, not empty: `dout <= mem[count-1]`, `count <= count-1`, `dvalid <= 1`.
- Tos, not empty: `dout <= mem[count-1]`, `count` unchanged, `dvalid <= 1`.
- Pop/tos, empty: `dout`/`count` unchanged, `dvalid <= 0`, `underflow <= 1`.
- `clr_err` clears both sticky flags; a new error in the same cycle wins (flag ends at 1).
- Popped entries are not cleared; a later push overwrites them.
- Arithmetic: `count` is CW bits, never wraps; array index is `count[CW-2:0]` (write) or `(count-1)[CW-2:0]` (read), evaluated only when guarded by not-full / not-empty.
- `empty` and `full` are combinational decodes of `count`.

## Timing
- All commands take effect on the rising edge at which the strobe is sampled; strobes are level-sampled each cycle (held strobe = repeated command).
- Latency: `dout`/`dvalid` valid the cycle after a pop or tos strobe; `count`, `empty`, `full` reflect the command the cycle after.
- Back-to-back: pop followed immediately by pop returns successive entries with no bubble; push then tos returns the pushed word.
- Internal FSM: `S_IDLE` (no output pending) and `S_OUT` (`dvalid` high). `S_IDLE`→`S_OUT` on successful pop/tos; `S_OUT`→`S_OUT` on another successful pop/tos, else →`S_IDLE`. `dvalid == (state == S_OUT)`.
- Reset (async assert, any time, including mid-command): `count=0`, `empty=1`, `full=0`, `dout=0`, `dvalid=0`, `overflow=0`, `underflow=0`, state `S_IDLE`; storage array not reset. Deassertion is synchronised upstream; first command is honoured on the first edge after release.

## Structure
- Shared package `stack_pkg`: `stack_cmd_e` (`CMD_NONE`, `CMD_PUSH`, `CMD_POP`, `CMD_TOS`) produced by the priority encoder, FSM state enum, default `WIDTH`/`DEPTH` constants used by the main controller and datapath.
- One sub-module `stack_regfile`: DEPTH×WIDTH register array, one synchronous write port, one combinational read port; no reset. Pointer logic, flags and FSM stay in `stack_ctrl`.

## Test plan
- Reset then push 0x11, 0x22, 0x33 on consecutive cycles, then pop ×3 -> `dout` 0x33, 0x22, 0x11 with `dvalid` high three cycles; `count` 3→0, `empty`=1 at end.
- Push 0xA5, tos twice -> `dout`=0xA5 both cycles, `count` stays 1, `dvalid` high two cycles.
- Push DEPTH words 0..15 then push 0xFF -> `full`=1, `overflow`=1, `count`=16; pop returns 0x0F (0xFF never stored).
- Pop on empty -> `underflow`=1, `dout` holds previous value, `dvalid`=0; `clr_err` alone clears it; `clr_err` coincident with another empty pop leaves `underflow`=1.
- Push, pop and tos all high with `din`=0x5C on a stack holding 0x01 -> push wins: `count`=2, `dout`=0x5C, `dvalid`=0.
- Assert `rst` low mid-sequence with `count`=5 and `dvalid`=1 -> all outputs immediately at reset values without a clock edge; tos after release -> `underflow`=1.
